// File: rtl/diff_demo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : diff_demo_pkg
//  Description : Shared types for the layer configuration sequencer: the
//                packed per-layer descriptor, the sequencer state encoding
//                and a helper that flags descriptors the engine cannot run.
//  Revision    : 1.0  initial release
// ============================================================================
package diff_demo_pkg;

    localparam int C_DESC_W = 35;

    // Field order fixes the bit layout seen on the cfg_desc write bus:
    // w in [34:27], h [26:19], c [18:11], co [10:3], modes in [2:0].
    typedef struct packed {
        logic [7:0] w;
        logic [7:0] h;
        logic [7:0] c;
        logic [7:0] co;
        logic       kernel_mode;
        logic       bit_mode;
        logic       is_diff;
    } layer_desc_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    // The engine computes (dimension - 1) internally, so a zero anywhere
    // would underflow; such layers are skipped rather than issued.
    function automatic logic desc_has_zero(input layer_desc_t d);
        return (d.w == 8'd0) || (d.h == 8'd0) || (d.c == 8'd0) || (d.co == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_desc_rf.sv
`default_nettype none
// ============================================================================
//  Module      : layer_desc_rf
//  Description : LAYER_NUM-entry flop register file of layer descriptors.
//                One synchronous write port, one combinational read port.
//                Contents are intentionally not reset.
//  Ports       : clk      - clock
//                i_we     - write strobe
//                i_waddr  - write address
//                i_wdata  - descriptor to write
//                i_raddr  - read address
//                o_rdata  - descriptor at i_raddr (zero when out of range)
//  Revision    : 1.0  initial release
// ============================================================================
module layer_desc_rf
    import diff_demo_pkg::*;
#(
    parameter int LAYER_NUM = 16,
    parameter int AW        = $clog2(LAYER_NUM)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [C_DESC_W-1:0] i_wdata,
    input  logic [AW-1:0]       i_raddr,
    output logic [C_DESC_W-1:0] o_rdata
);

    logic [C_DESC_W-1:0] r_mem [LAYER_NUM];

    // Addresses past the table depth (non power-of-two depth) are dropped.
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < LAYER_NUM)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (32'(i_raddr) < LAYER_NUM) ? r_mem[i_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/layer_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : layer_cfg_seq
//  Description : Layer configuration sequencer. Holds a host-written table of
//                layer descriptors and, on start, offers them one at a time to
//                the engine over ctrl_valid/ctrl_ready, waiting for
//                ctrl_finish before moving to the next layer.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                cfg_we/addr/desc   - descriptor table write (IDLE only)
//                start, layer_cnt   - run request and run length (IDLE only)
//                abort              - stop request
//                ctrl_valid/ready   - descriptor offer handshake to engine
//                ctrl_finish        - engine layer-complete pulse
//                w/h/c/co_num, modes, is_first - issued descriptor
//                busy, cur_layer, layer_cycles - progress/status
//                done, aborted      - end-of-run pulses
//                err                - sticky zero-dimension flag
//  Revision    : 1.0  initial release
// ============================================================================
module layer_cfg_seq
    import diff_demo_pkg::*;
#(
    parameter int LAYER_NUM = 16,
    parameter int AW        = $clog2(LAYER_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [C_DESC_W-1:0] cfg_desc,
    input  logic                start,
    input  logic [AW:0]         layer_cnt,
    input  logic                abort,
    output logic                ctrl_valid,
    input  logic                ctrl_ready,
    input  logic                ctrl_finish,
    output logic [7:0]          w_num,
    output logic [7:0]          h_num,
    output logic [7:0]          c_num,
    output logic [7:0]          co_num,
    output logic                kernel_mode,
    output logic                bit_mode,
    output logic                is_diff,
    output logic                is_first,
    output logic                busy,
    output logic [AW-1:0]       cur_layer,
    output logic [31:0]         layer_cycles,
    output logic                done,
    output logic                aborted,
    output logic                err
);

    localparam logic [AW:0] C_LAYER_NUM = (AW+1)'(LAYER_NUM);

    seq_state_e          r_state;
    seq_state_e          w_next;
    logic [AW:0]         r_num;
    logic [AW-1:0]       r_cur;
    logic [31:0]         r_cnt;
    logic [31:0]         w_cnt_inc;
    logic [31:0]         r_layer_cycles;
    logic                r_abort_pend;
    logic                r_is_first;
    logic                r_err;
    logic                r_aborted;
    layer_desc_t         r_desc;
    layer_desc_t         w_rd;
    logic [C_DESC_W-1:0] w_rd_bits;
    logic [AW:0]         w_clamped;
    logic                w_cfg_we;
    logic                w_zero;
    logic                w_last;
    logic                w_fin_abort;
    logic                w_adv;
    logic                w_abort_now;

    assign w_cfg_we = cfg_we && (r_state == S_IDLE);

    layer_desc_rf #(
        .LAYER_NUM (LAYER_NUM),
        .AW        (AW)
    ) u_rf (
        .clk     (clk),
        .i_we    (w_cfg_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_desc),
        .i_raddr (r_cur),
        .o_rdata (w_rd_bits)
    );

    assign w_rd        = layer_desc_t'(w_rd_bits);
    assign w_zero      = desc_has_zero(w_rd);
    assign w_clamped   = (layer_cnt > C_LAYER_NUM) ? C_LAYER_NUM : layer_cnt;
    assign w_last      = (({1'b0, r_cur} + (AW+1)'(1)) == r_num);
    assign w_cnt_inc   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    // An abort raised in the same cycle as the finish still counts.
    assign w_fin_abort = r_abort_pend || abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_adv       = 1'b0;
        w_abort_now = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (layer_cnt == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next      = S_IDLE;
                    w_abort_now = 1'b1;
                end else if (w_zero) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LOAD;
                        w_adv  = 1'b1;
                    end
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A completed handshake wins over a same-cycle abort: the
                // engine has taken the layer, so it must be drained in WAIT.
                if (ctrl_ready) begin
                    w_next = S_WAIT;
                end else if (abort) begin
                    w_next      = S_IDLE;
                    w_abort_now = 1'b1;
                end
            end
            S_WAIT: begin
                if (ctrl_finish) begin
                    if (w_fin_abort) begin
                        w_next      = S_IDLE;
                        w_abort_now = 1'b1;
                    end else if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LOAD;
                        w_adv  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num          <= '0;
            r_cur          <= '0;
            r_cnt          <= '0;
            r_layer_cycles <= '0;
            r_abort_pend   <= 1'b0;
            r_is_first     <= 1'b0;
            r_err          <= 1'b0;
            r_aborted      <= 1'b0;
            r_desc         <= '0;
        end else begin
            r_aborted <= w_abort_now;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num        <= w_clamped;
                        r_cur        <= '0;
                        r_err        <= 1'b0;
                        r_abort_pend <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_desc     <= w_rd;
                    r_is_first <= (r_cur == '0);
                    if (!abort && w_zero) begin
                        r_err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (ctrl_ready) begin
                        r_cnt        <= '0;
                        r_abort_pend <= abort;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (ctrl_finish) begin
                        r_layer_cycles <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
            if (w_adv) begin
                r_cur <= r_cur + AW'(1);
            end
        end
    end

    assign ctrl_valid   = (r_state == S_ISSUE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign aborted      = r_aborted;
    assign err          = r_err;
    assign cur_layer    = r_cur;
    assign layer_cycles = r_layer_cycles;
    assign is_first     = r_is_first;
    assign w_num        = r_desc.w;
    assign h_num        = r_desc.h;
    assign c_num        = r_desc.c;
    assign co_num       = r_desc.co;
    assign kernel_mode  = r_desc.kernel_mode;
    assign bit_mode     = r_desc.bit_mode;
    assign is_diff      = r_desc.is_diff;

endmodule
`default_nettype wire

// File: doc/layer_cfg_seq.md
# layer_cfg_seq

Layer configuration sequencer: the initiator side of the `ctrl_valid`/`ctrl_ready`/`ctrl_finish` layer handshake used by the feature-map guard generation controller.

- Holds a small table of per-layer descriptors, written by the host.
- On `start`, issues each descriptor in order, and only issues the next one after the engine reports `ctrl_finish`.
- Sits between the host/config bus and the engine control port.
- Reports progress, per-layer cycle counts, completion, abort and descriptor errors.

## Interface
Parameters:
- `LAYER_NUM`, default 16: descriptor table depth.
- `AW`, default `$clog2(LAYER_NUM)`: table address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `cfg_we` in 1: descriptor write strobe. Ignored while `busy`.
- `cfg_addr` in AW: descriptor write address.
- `cfg_desc` in 35: `layer_desc_t` write data.
- `start` in 1: begin a run of `layer_cnt` layers. Ignored while `busy`.
- `layer_cnt` in AW+1: number of layers in the run, 0..LAYER_NUM.
- `abort` in 1: request stop.
- `ctrl_valid` out 1: descriptor offered to the engine.
- `ctrl_ready` in 1: engine idle and accepting.
- `ctrl_finish` in 1: one-cycle pulse, engine has completed the layer.
- `w_num`, `h_num`, `c_num`, `co_num` out 8 each: layer dimensions.
- `kernel_mode`, `bit_mode`, `is_diff` out 1 each: layer modes.
- `is_first` out 1: high only for run layer 0.
- `busy` out 1: state != IDLE.
- `cur_layer` out AW: index of the layer being issued or executed.
- `layer_cycles` out 32: cycles from accept to finish of the last completed layer.
- `done` out 1: one-cycle pulse, run completed normally.
- `aborted` out 1: one-cycle pulse, run ended by `abort`.
- `err` out 1: sticky, set on a zero-dimension descriptor, cleared by the next accepted `start`.

## Operation
States: IDLE, LOAD, ISSUE, WAIT, DONE.

- **IDLE:** writes are accepted: `cfg_we` writes `cfg_desc` to the table entry at `cfg_addr`.
  - `start` with `layer_cnt`=0 → DONE.
  - `start` with `layer_cnt`>0 → LOAD, with `cur_layer`=0.
- **LOAD:** register `table[cur_layer]` onto the descriptor outputs; `is_first` = (`cur_layer`==0).
  - If any of w, h, c, co == 0: set `err` and skip the layer (the engine computes n-1 and would underflow). Go to LOAD for the next layer, or to DONE if it was the last layer.
  - Otherwise → ISSUE.
- **ISSUE:** `ctrl_valid`=1. Outputs stay stable until `ctrl_valid && ctrl_ready`.
  - On that handshake: → WAIT, clear the cycle counter.
  - `ctrl_finish` seen in ISSUE is ignored.
- **WAIT:** `ctrl_valid`=0; the cycle counter increments every cycle.
  - On `ctrl_finish`: latch `layer_cycles` = counter+1.
  - Then: if this was the last layer → DONE, else `cur_layer`++ → LOAD.
- **DONE:** pulse `done` → IDLE.

Abort:
- In LOAD or ISSUE: `ctrl_valid` drops in the next cycle, pulse `aborted`, → IDLE. No layer has been accepted, so nothing needs draining.
- In WAIT: latch `abort_pend` and keep waiting. On `ctrl_finish`, pulse `aborted` (not `done`) → IDLE. A layer the engine has accepted cannot be cancelled.
- `abort` in IDLE or DONE: no effect.

Arithmetic:
- The cycle counter saturates at 32'hFFFF_FFFF.
- `layer_cnt` greater than LAYER_NUM is clamped to LAYER_NUM.

## Timing
- Reset values: all outputs 0, state IDLE, `cur_layer`=0, `err`=0. Table contents are not reset.
- `start` sampled at edge k: LOAD in cycle k+1; `ctrl_valid` high from cycle k+2.
- Handshake at edge a: `ctrl_valid` low in cycle a+1.
- `ctrl_finish` at edge f:
  - not the last layer: LOAD in cycle f+1, next `ctrl_valid` in cycle f+2;
  - last layer: `done` high in cycle f+1, `busy` low in cycle f+2.
- Layer-to-layer handoff: the engine raises `ctrl_ready` one cycle after its finish pulse, and `ctrl_valid` arriving at f+2 meets it with no extra wait.
- `cfg_we` together with `start` in the same IDLE cycle: the write is committed and the run uses the new data. LOAD reads in a later cycle.
- `rst` mid-run: state goes to IDLE and `ctrl_valid` drops on the next edge. The engine must be reset together with this block.

## Structure
- Package `diff_demo_pkg` holds:
  - `typedef struct packed {w, h, c, co [7:0]; kernel_mode; bit_mode; is_diff} layer_desc_t` (35 bits);
  - the state enum `seq_state_e`.
- Sub-module `layer_desc_rf`: LAYER_NUM × `layer_desc_t` flop register file, with one synchronous write port and one combinational read port. The sequencer FSM, counters and output registers live in `layer_cfg_seq`.

## Test plan
- Table {8,8,4,4,…}, {12,6,8,4,…}, `layer_cnt`=2, engine model finishing 20 cycles after accept:
  - two handshakes, `is_first` 1 then 0;
  - `layer_cycles`=20 after each layer;
  - `done` exactly 1 cycle after the second finish.
- `ctrl_ready` held low 5 cycles after ISSUE entry → `ctrl_valid` and all fields stay stable for 5 cycles, then a single accept.
- Layer 1 with c=0, `layer_cnt`=3 → `err`=1, only layers 0 and 2 are issued, `done` still pulses.
- `abort` during WAIT of layer 0 of 3 → no new `ctrl_valid`; `aborted` the cycle after finish; `done` never.
- `abort` during ISSUE → `ctrl_valid` low next cycle, `aborted` pulse, `busy`=0.
- `start` while busy, `cfg_we` while busy, and `layer_cnt`=0 → the first two are ignored (table unchanged); `layer_cnt`=0 gives `done` in cycle k+1 with no `ctrl_valid`.
